// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word size, instruction
// field positions, the default reset PC and the buffered fetch entry.
package instr_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small FIFO of {pc, word} fetch entries with a flush that empties it in one cycle.
// Flush wins over a same-cycle write or read.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  fetch_entry_t  wr_data,
    input  logic          rd_en,
    output fetch_entry_t  rd_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wr_data;
    end

    // Upstream slot reservation must make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_en) assert (count != CW'(DEPTH));
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word fetches, buffers in-order responses
// with their PC, and discards responses belonging to a redirected path.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      Op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] branch_target
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int DW = 8;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   count;
    logic [DW-1:0]   drop_cnt;
    logic            req_fire;
    logic            stale;
    logic            rsp_live;
    logic            accept;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;

    // Slots are reserved at request time, so live responses always find room.
    // rst gating keeps the request quiet while reset is held.
    assign imem_req_valid = !rst && ((int'(inflight) + int'(count)) < BUF_DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding predates the last reset and is ignored.
    assign stale    = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (inflight != '0);
    assign accept   = instr_valid && instr_ready;
    assign wr_entry = {rsp_pc, imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (PCSrc) begin
            // Everything still outstanding, including this cycle's request, is now stale.
            fetch_pc <= align_word(branch_target);
            rsp_pc   <= align_word(branch_target);
            inflight <= '0;
            drop_cnt <= drop_cnt + DW'(inflight) + DW'(req_fire) - DW'(stale || rsp_live);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_live) rsp_pc <= rsp_pc + 32'd4;
            inflight <= inflight + CW'(req_fire) - CW'(rsp_live);
            if (stale) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (PCSrc),
        .wr_en   (rsp_live && !PCSrc),
        .wr_data (wr_entry),
        .rd_en   (accept),
        .rd_data (head),
        .count   (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.word : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign Op          = instr[OP_MSB:OP_LSB];
    assign funct3      = instr[F3_MSB:F3_LSB];
    assign funct7      = instr[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: latency-configurable in-order memory
// model, PC scoreboard checked on every accept, redirect vector table and corner sequences.
module tb_instr_fetch_unit;

    localparam int DEPTH = 3;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_target = 32'h0;

    instr_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .Op             (Op),
        .funct3         (funct3),
        .funct7         (funct7),
        .PCSrc          (PCSrc),
        .branch_target  (branch_target)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int lat = 1;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mq_data[$];
    int          mq_due[$];
    logic        mem_hs;
    logic [31:0] mem_addr;
    logic [31:0] mon_pc;
    logic [31:0] mon_w;
    logic [31:0] tgt;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
    } redir_vec_t;
    redir_vec_t tbl[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0101_0103) ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_stream(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int maxc);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: instr_valid never rose within %0d cycles", name, maxc);
        end
    endtask

    task automatic do_reset(input int l);
        int n;
        n = 0;
        tick();
        rst = 1'b1;
        PCSrc = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        while (mq_due.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        lat = l;
        start_stream(RPC);
        rst = 1'b0;
    endtask

    // In-order memory: a handshake seen before edge n is answered right after edge n+lat-1.
    always begin
        @(negedge clk);
        mem_hs   = imem_req_valid && imem_req_ready;
        mem_addr = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_hs) begin
            mq_data.push_back(mem_word(mem_addr));
            mq_due.push_back(cyc + lat - 1);
        end
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_data.pop_front();
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // Scoreboard: every accepted instruction must be the next expected PC and its word.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got pc %h, expected no instruction", instr_pc);
                end else begin
                    mon_pc = exp_q.pop_front();
                    mon_w  = mem_word(mon_pc);
                    chk("acc_pc", instr_pc, mon_pc);
                    chk("acc_instr", instr, mon_w);
                    chk("acc_fields", {15'b0, Op, funct3, funct7},
                        {15'b0, mon_w[6:0], mon_w[14:12], mon_w[31:25]});
                    acc_cnt++;
                end
            end else if (!instr_valid) begin
                chk("idle_zero", instr | instr_pc | {15'b0, Op, funct3, funct7}, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int nreq;
        tbl[0] = '{32'h0000_0103, 32'h0000_0100};
        tbl[1] = '{32'h0000_0002, 32'h0000_0000};
        tbl[2] = '{32'h8000_0005, 32'h8000_0004};
        tbl[3] = '{32'h0000_0040, 32'h0000_0040};
        tbl[4] = '{32'hFFFF_FFF7, 32'hFFFF_FFF4};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instr_zero", instr, 0);

        // Release with ready memory and decoder: first request at RESET_PC, then 1/cycle
        start_stream(RPC);
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, RPC);
        wait_valid("fill", 10);
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", instr_valid, 1);
            chk("stream_pc", instr_pc, RPC + 32'(4 * k));
            @(negedge clk);
        end

        // Decoder stalled: exactly DEPTH requests, then request drops and nothing is lost
        do_reset(1);
        imem_req_ready = 1'b1;
        nreq = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        chk("stall_req_count", nreq, DEPTH);
        chk("stall_req_valid_low", imem_req_valid, 0);
        chk("stall_instr_valid", instr_valid, 1);
        tick();
        acc0 = acc_cnt;
        instr_ready = 1'b1;
        imem_req_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("stall_no_loss", acc_cnt - acc0, DEPTH);

        // Redirect with two requests in flight, misaligned target
        do_reset(4);
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        PCSrc = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        PCSrc = 1'b0;
        start_stream(32'h0000_0100);
        @(negedge clk);
        chk("redir_addr", imem_req_addr, 32'h0000_0100);
        chk("redir_req_valid", imem_req_valid, 1);
        chk("redir_instr_valid", instr_valid, 0);
        tick();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        wait_valid("redir_fill", 20);
        chk("redir_first_pc", instr_pc, 32'h0000_0100);
        chk("redir_first_instr", instr, mem_word(32'h0000_0100));
        repeat (10) @(negedge clk);

        // Redirect in the same cycle as an accept, then request held while memory stalls
        do_reset(1);
        imem_req_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("full_instr_valid", instr_valid, 1);
        chk("full_req_valid", imem_req_valid, 0);
        tick();
        acc0 = acc_cnt;
        instr_ready = 1'b1;
        imem_req_ready = 1'b0;
        PCSrc = 1'b1;
        branch_target = 32'h0000_0300;
        tick();
        PCSrc = 1'b0;
        instr_ready = 1'b0;
        start_stream(32'h0000_0300);
        @(negedge clk);
        chk("same_cycle_accept_once", acc_cnt - acc0, 1);
        chk("flush_instr_valid", instr_valid, 0);
        chk("flush_instr_pc", instr_pc, 0);
        for (int k = 0; k < 5; k++) begin
            chk("hold_addr", imem_req_addr, 32'h0000_0300);
            chk("hold_req_valid", imem_req_valid, 1);
            @(negedge clk);
        end
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("after_hs_addr", imem_req_addr, 32'h0000_0304);
        tick();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        wait_valid("hold_fill", 10);
        chk("hold_first_pc", instr_pc, 32'h0000_0300);

        // Redirect vector table: target alignment, request re-issued, buffer empty
        tick();
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            PCSrc = 1'b1;
            branch_target = tbl[i].target;
            tick();
            PCSrc = 1'b0;
            start_stream(tbl[i].exp_addr);
            @(negedge clk);
            chk("tbl_addr", imem_req_addr, tbl[i].exp_addr);
            chk("tbl_req_valid", imem_req_valid, 1);
            chk("tbl_instr_valid", instr_valid, 0);
        end
        tick();
        lat = 2;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        wait_valid("tbl_resume", 20);
        chk("tbl_resume_pc", instr_pc, tbl[4].exp_addr);

        // Random ready patterns with occasional redirects; scoreboard checks order
        acc0 = acc_cnt;
        for (int i = 0; i < 200; i++) begin
            tick();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                tgt = $urandom;
                PCSrc = 1'b1;
                branch_target = tgt;
                tick();
                PCSrc = 1'b0;
                start_stream({tgt[31:2], 2'b00});
            end
        end
        chk("random_progress", 32'((acc_cnt - acc0) > 40), 1);

        // Reset with one request in flight; its response lands right after release
        do_reset(2);
        PCSrc = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        PCSrc = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_stream(RPC);
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        wait_valid("post_rst_fill", 20);
        chk("post_rst_first_pc", instr_pc, RPC);
        chk("post_rst_first_instr", instr, mem_word(RPC));
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
